// File: rtl/pspin_tx_merge.sv
// -----------------------------------------------------------------------------
// pspin_tx_merge
//
// Merges the host NIC TX AXI-Stream and the PsPIN egress AXI-Stream into the
// single NIC TX stream toward the MAC. Arbitration is frame-atomic: once a
// source is granted, only its beats are forwarded until its tlast. Frames
// longer than MERGE_MTU bytes are cut at MAX_BEATS beats. The cut beat carries
// a forced tlast and a forced tuser[0] (bad-frame flag). The rest of that input
// frame is then drained and discarded, so a runaway source cannot block the
// other one.
//
// Ports
//   clk, rstn               single clock, asynchronous active-low reset
//   s_axis_nic_tx_*         host TX source (tready is an output)
//   s_axis_pspin_tx_*       PsPIN TX source (tready is an output)
//   m_axis_nic_tx_*         merged output stream, single register stage
//   prio_pspin              1 = strict PsPIN priority, 0 = round-robin;
//                           only looked at while idle
//   stat_nic_frames         frames emitted from the host source
//   stat_pspin_frames       frames emitted from the PsPIN source
//   stat_trunc_frames       frames cut at MAX_BEATS
//
// Build option
//   PSPIN_TX_MERGE_STATS_EN  when defined, the three 32-bit wrapping frame
//                            counters are built. Otherwise the stat ports
//                            are tied to 0.
// -----------------------------------------------------------------------------
module pspin_tx_merge #(
  parameter int AXIS_IF_DATA_WIDTH    = 512,
  parameter int AXIS_IF_KEEP_WIDTH    = AXIS_IF_DATA_WIDTH / 8,
  parameter int AXIS_IF_TX_ID_WIDTH   = 1,
  parameter int AXIS_IF_TX_DEST_WIDTH = 8,
  parameter int AXIS_IF_TX_USER_WIDTH = 17,
  parameter int MERGE_MTU             = 1500
) (
  input  logic                             clk,
  input  logic                             rstn,

  input  logic [AXIS_IF_DATA_WIDTH-1:0]    s_axis_nic_tx_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0]    s_axis_nic_tx_tkeep,
  input  logic                             s_axis_nic_tx_tvalid,
  output logic                             s_axis_nic_tx_tready,
  input  logic                             s_axis_nic_tx_tlast,
  input  logic [AXIS_IF_TX_ID_WIDTH-1:0]   s_axis_nic_tx_tid,
  input  logic [AXIS_IF_TX_DEST_WIDTH-1:0] s_axis_nic_tx_tdest,
  input  logic [AXIS_IF_TX_USER_WIDTH-1:0] s_axis_nic_tx_tuser,

  input  logic [AXIS_IF_DATA_WIDTH-1:0]    s_axis_pspin_tx_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0]    s_axis_pspin_tx_tkeep,
  input  logic                             s_axis_pspin_tx_tvalid,
  output logic                             s_axis_pspin_tx_tready,
  input  logic                             s_axis_pspin_tx_tlast,
  input  logic [AXIS_IF_TX_ID_WIDTH-1:0]   s_axis_pspin_tx_tid,
  input  logic [AXIS_IF_TX_DEST_WIDTH-1:0] s_axis_pspin_tx_tdest,
  input  logic [AXIS_IF_TX_USER_WIDTH-1:0] s_axis_pspin_tx_tuser,

  output logic [AXIS_IF_DATA_WIDTH-1:0]    m_axis_nic_tx_tdata,
  output logic [AXIS_IF_KEEP_WIDTH-1:0]    m_axis_nic_tx_tkeep,
  output logic                             m_axis_nic_tx_tvalid,
  input  logic                             m_axis_nic_tx_tready,
  output logic                             m_axis_nic_tx_tlast,
  output logic [AXIS_IF_TX_ID_WIDTH-1:0]   m_axis_nic_tx_tid,
  output logic [AXIS_IF_TX_DEST_WIDTH-1:0] m_axis_nic_tx_tdest,
  output logic [AXIS_IF_TX_USER_WIDTH-1:0] m_axis_nic_tx_tuser,

  input  logic                             prio_pspin,

  output logic [31:0]                      stat_nic_frames,
  output logic [31:0]                      stat_pspin_frames,
  output logic [31:0]                      stat_trunc_frames
);

  localparam int MAX_BEATS = (MERGE_MTU * 8 + AXIS_IF_DATA_WIDTH - 1) / AXIS_IF_DATA_WIDTH;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    PASS_NIC,
    PASS_PSPIN,
    DROP_NIC,
    DROP_PSPIN
  } state_t;

  state_t             state, state_nxt;
  logic               last_ps, last_ps_nxt;   // 1 = PsPIN was granted last
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [CNT_W-1:0]   beat_inc;

  logic               grant_ps;
  logic               out_free;
  logic               src_ready;
  logic               load;
  logic               force_last;
  logic               win_ps;

  // Beat of the currently granted source
  logic                             src_valid;
  logic                             src_last;
  logic [AXIS_IF_DATA_WIDTH-1:0]    src_data;
  logic [AXIS_IF_KEEP_WIDTH-1:0]    src_keep;
  logic [AXIS_IF_TX_ID_WIDTH-1:0]   src_id;
  logic [AXIS_IF_TX_DEST_WIDTH-1:0] src_dest;
  logic [AXIS_IF_TX_USER_WIDTH-1:0] src_user;
  logic [AXIS_IF_TX_USER_WIDTH-1:0] out_user;

  assign grant_ps = (state == PASS_PSPIN) || (state == DROP_PSPIN);
  assign out_free = !m_axis_nic_tx_tvalid || m_axis_nic_tx_tready;
  assign beat_inc = beat_cnt + 1'b1;

  always_comb begin
    if (grant_ps) begin
      src_valid = s_axis_pspin_tx_tvalid;
      src_last  = s_axis_pspin_tx_tlast;
      src_data  = s_axis_pspin_tx_tdata;
      src_keep  = s_axis_pspin_tx_tkeep;
      src_id    = s_axis_pspin_tx_tid;
      src_dest  = s_axis_pspin_tx_tdest;
      src_user  = s_axis_pspin_tx_tuser;
    end else begin
      src_valid = s_axis_nic_tx_tvalid;
      src_last  = s_axis_nic_tx_tlast;
      src_data  = s_axis_nic_tx_tdata;
      src_keep  = s_axis_nic_tx_tkeep;
      src_id    = s_axis_nic_tx_tid;
      src_dest  = s_axis_nic_tx_tdest;
      src_user  = s_axis_nic_tx_tuser;
    end
  end

  // Next-state and handshake logic
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    last_ps_nxt  = last_ps;
    beat_cnt_nxt = beat_cnt;
    src_ready    = 1'b0;
    load         = 1'b0;
    force_last   = 1'b0;
    win_ps       = 1'b0;

    unique case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (s_axis_nic_tx_tvalid && s_axis_pspin_tx_tvalid) begin
          // Tie: strict priority, or whoever was not served last
          win_ps = prio_pspin ? 1'b1 : !last_ps;
        end else begin
          win_ps = s_axis_pspin_tx_tvalid;
        end
        if (s_axis_nic_tx_tvalid || s_axis_pspin_tx_tvalid) begin
          state_nxt = win_ps ? PASS_PSPIN : PASS_NIC;
        end
      end

      PASS_NIC, PASS_PSPIN: begin
        src_ready = out_free;
        if (src_valid && out_free) begin
          load         = 1'b1;
          beat_cnt_nxt = beat_inc;
          if (src_last) begin
            state_nxt   = IDLE;
            last_ps_nxt = grant_ps;
          end else if (beat_inc == LAST_BEAT) begin
            // Frame has hit the MTU: close it on the output and drain the rest
            force_last = 1'b1;
            state_nxt  = grant_ps ? DROP_PSPIN : DROP_NIC;
          end
        end
      end

      DROP_NIC, DROP_PSPIN: begin
        src_ready = 1'b1;
        if (src_valid && src_last) begin
          state_nxt   = IDLE;
          last_ps_nxt = grant_ps;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign s_axis_nic_tx_tready   = src_ready && !grant_ps;
  assign s_axis_pspin_tx_tready = src_ready &&  grant_ps;

  always_comb begin
    out_user = src_user;
    if (force_last) out_user[0] = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      last_ps  <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_ps  <= last_ps_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Output register. The held beat stays put while the MAC stalls.
  // NOTE: the wide data register is reset too because the MAC-side outputs
  // must read 0 during and right after reset, not just tvalid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axis_nic_tx_tvalid <= 1'b0;
      m_axis_nic_tx_tdata  <= '0;
      m_axis_nic_tx_tkeep  <= '0;
      m_axis_nic_tx_tlast  <= 1'b0;
      m_axis_nic_tx_tid    <= '0;
      m_axis_nic_tx_tdest  <= '0;
      m_axis_nic_tx_tuser  <= '0;
    end else if (load) begin
      m_axis_nic_tx_tvalid <= 1'b1;
      m_axis_nic_tx_tdata  <= src_data;
      m_axis_nic_tx_tkeep  <= src_keep;
      m_axis_nic_tx_tlast  <= src_last || force_last;
      m_axis_nic_tx_tid    <= src_id;
      m_axis_nic_tx_tdest  <= src_dest;
      m_axis_nic_tx_tuser  <= out_user;
    end else if (m_axis_nic_tx_tready) begin
      m_axis_nic_tx_tvalid <= 1'b0;
    end
  end

`ifdef PSPIN_TX_MERGE_STATS_EN
  logic [31:0] nic_frames_q;
  logic [31:0] pspin_frames_q;
  logic [31:0] trunc_frames_q;
  logic        frame_end;

  // A frame is counted when its final output beat enters the output register
  assign frame_end = load && (src_last || force_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nic_frames_q   <= '0;
      pspin_frames_q <= '0;
      trunc_frames_q <= '0;
    end else begin
      if (frame_end && !grant_ps) nic_frames_q   <= nic_frames_q + 32'd1;
      if (frame_end &&  grant_ps) pspin_frames_q <= pspin_frames_q + 32'd1;
      if (force_last)             trunc_frames_q <= trunc_frames_q + 32'd1;
    end
  end

  assign stat_nic_frames   = nic_frames_q;
  assign stat_pspin_frames = pspin_frames_q;
  assign stat_trunc_frames = trunc_frames_q;
`else
  assign stat_nic_frames   = '0;
  assign stat_pspin_frames = '0;
  assign stat_trunc_frames = '0;
`endif

endmodule

// File: tb/tb_pspin_tx_merge.sv
// -----------------------------------------------------------------------------
// tb_pspin_tx_merge
//
// Self-checking bench for pspin_tx_merge. A table of idle-arbitration vectors
// is followed by frame-level traffic runs. In these runs the expected output
// stream comes from a frame-queue model: it picks frames by policy and cuts
// them at MAX_BEATS.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pspin_tx_merge;

  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int IW  = 1;
  localparam int DSW = 8;
  localparam int UW  = 17;
  localparam int MTU = 1500;
  localparam int MAX_BEATS = (MTU * 8 + DW - 1) / DW;
  localparam int BW  = DW + KW + 1 + IW + DSW + UW;
  localparam int CW  = 640;

  typedef struct {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } beat_t;

  typedef struct {
    bit prio;
    bit nic_v;
    bit ps_v;
    bit exp_nic_rdy;
    bit exp_ps_rdy;
  } arb_vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [DW-1:0]  nic_data, ps_data, m_data;
  logic [KW-1:0]  nic_keep, ps_keep, m_keep;
  logic           nic_v, ps_v, m_valid;
  logic           nic_rdy, ps_rdy, m_tready;
  logic           nic_last, ps_last, m_last;
  logic [IW-1:0]  nic_id, ps_id, m_id;
  logic [DSW-1:0] nic_dest, ps_dest, m_dest;
  logic [UW-1:0]  nic_user, ps_user, m_user;
  logic           prio_pspin;
  logic [31:0]    stat_nic, stat_ps, stat_trunc;

  always #5 clk = ~clk;

  pspin_tx_merge dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .s_axis_nic_tx_tdata    (nic_data),
    .s_axis_nic_tx_tkeep    (nic_keep),
    .s_axis_nic_tx_tvalid   (nic_v),
    .s_axis_nic_tx_tready   (nic_rdy),
    .s_axis_nic_tx_tlast    (nic_last),
    .s_axis_nic_tx_tid      (nic_id),
    .s_axis_nic_tx_tdest    (nic_dest),
    .s_axis_nic_tx_tuser    (nic_user),
    .s_axis_pspin_tx_tdata  (ps_data),
    .s_axis_pspin_tx_tkeep  (ps_keep),
    .s_axis_pspin_tx_tvalid (ps_v),
    .s_axis_pspin_tx_tready (ps_rdy),
    .s_axis_pspin_tx_tlast  (ps_last),
    .s_axis_pspin_tx_tid    (ps_id),
    .s_axis_pspin_tx_tdest  (ps_dest),
    .s_axis_pspin_tx_tuser  (ps_user),
    .m_axis_nic_tx_tdata    (m_data),
    .m_axis_nic_tx_tkeep    (m_keep),
    .m_axis_nic_tx_tvalid   (m_valid),
    .m_axis_nic_tx_tready   (m_tready),
    .m_axis_nic_tx_tlast    (m_last),
    .m_axis_nic_tx_tid      (m_id),
    .m_axis_nic_tx_tdest    (m_dest),
    .m_axis_nic_tx_tuser    (m_user),
    .prio_pspin             (prio_pspin),
    .stat_nic_frames        (stat_nic),
    .stat_pspin_frames      (stat_ps),
    .stat_trunc_frames      (stat_trunc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  beat_t nic_q[$];
  beat_t ps_q[$];
  beat_t exp_q[$];
  bit    model_last_ps = 1'b1;
  int    exp_nic = 0;
  int    exp_ps = 0;
  int    exp_trunc = 0;
  bit    rpat [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack(input beat_t b);
    return {b.data, b.keep, b.last, b.id, b.dest, b.user};
  endfunction

  function automatic logic [BW-1:0] m_pack();
    return {m_data, m_keep, m_last, m_id, m_dest, m_user};
  endfunction

  task automatic gen_frame(input bit to_ps, input int len, input logic [KW-1:0] keep_last,
                           input logic [IW-1:0] id, input logic [DSW-1:0] dest,
                           input logic [UW-1:0] user);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.keep = (i == len - 1) ? keep_last : '1;
      b.last = (i == len - 1);
      b.id   = id;
      b.dest = dest;
      b.user = user;
      if (to_ps) ps_q.push_back(b);
      else       nic_q.push_back(b);
    end
  endtask

  task automatic gen_random_frame(input bit to_ps, input int len);
    gen_frame(to_ps, len, {$urandom, $urandom}, IW'($urandom), DSW'($urandom), UW'($urandom));
  endtask

  // Frame-level reference: choose whole frames by policy, cut at MAX_BEATS.
  // Assumes every pending source shows its first beat whenever the merger idles.
  function automatic void build_expected(input bit prio);
    beat_t nq[$];
    beat_t pq[$];
    beat_t b;
    beat_t e;
    bit    take_ps;
    bit    done;
    int    n;
    nq = nic_q;
    pq = ps_q;
    while (nq.size() > 0 || pq.size() > 0) begin
      if (nq.size() > 0 && pq.size() > 0) take_ps = prio ? 1'b1 : !model_last_ps;
      else                                take_ps = (pq.size() > 0);
      model_last_ps = take_ps;
      if (take_ps) exp_ps++;
      else         exp_nic++;
      n = 0;
      done = 1'b0;
      while (!done) begin
        b = take_ps ? pq.pop_front() : nq.pop_front();
        n++;
        done = b.last;
        if (n <= MAX_BEATS) begin
          e = b;
          if (n == MAX_BEATS && !b.last) begin
            e.last    = 1'b1;
            e.user[0] = 1'b1;
            exp_trunc++;
          end
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  task automatic drive(input int rmode, input bit vgaps, input int cyc,
                       input bit nic_first, input bit ps_first);
    beat_t b;
    if (nic_q.size() > 0) begin
      b = nic_q[0];
      {nic_data, nic_keep, nic_last, nic_id, nic_dest, nic_user} = pack(b);
      nic_v = nic_first || !vgaps || ($urandom_range(0, 3) != 0);
    end else begin
      nic_v = 1'b0;
    end
    if (ps_q.size() > 0) begin
      b = ps_q[0];
      {ps_data, ps_keep, ps_last, ps_id, ps_dest, ps_user} = pack(b);
      ps_v = ps_first || !vgaps || ($urandom_range(0, 3) != 0);
    end else begin
      ps_v = 1'b0;
    end
    case (rmode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = (cyc < 7) ? rpat[cyc] : 1'b1;
    endcase
  endtask

  task automatic check_stats(input string tag);
`ifdef PSPIN_TX_MERGE_STATS_EN
    check({tag, " stats"}, CW'({stat_nic, stat_ps, stat_trunc}),
          CW'({32'(exp_nic), 32'(exp_ps), 32'(exp_trunc)}));
`else
    check({tag, " stats tied"}, CW'({stat_nic, stat_ps, stat_trunc}), CW'(0));
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " m outputs"}, CW'({m_valid, m_pack()}), CW'(0));
    check({tag, " s tready"}, CW'({nic_rdy, ps_rdy}), CW'(0));
    check({tag, " stats zero"}, CW'({stat_nic, stat_ps, stat_trunc}), CW'(0));
  endtask

  task automatic apply_reset();
    nic_v = 1'b0; ps_v = 1'b0; m_tready = 1'b0; prio_pspin = 1'b0;
    nic_last = 1'b0; ps_last = 1'b0;
    nic_data = '0; nic_keep = '0; nic_id = '0; nic_dest = '0; nic_user = '0;
    ps_data = '0; ps_keep = '0; ps_id = '0; ps_dest = '0; ps_user = '0;
    #2 rstn = 1'b0;
    nic_q.delete(); ps_q.delete(); exp_q.delete();
    model_last_ps = 1'b1;
    exp_nic = 0; exp_ps = 0; exp_trunc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Drives the queued frames, compares every output beat with the model.
  // stop_after > 0 abandons the run after that many cycles (no end checks).
  task automatic run_traffic(input string tag, input bit prio, input int rmode, input bit vgaps,
                             input bit chk_gap, input bit chk_mirror, input int stop_after);
    int    cyc = 0;
    int    last_out_cyc = 0;
    bit    out_first = 1'b1;
    bit    nic_first = 1'b1;
    bit    ps_first = 1'b1;
    bit    prev_stall = 1'b0;
    bit    out_free;
    bit    nic_fire, ps_fire, m_fire;
    logic [BW-1:0] snap = '0;
    beat_t b;
    beat_t e;
    @(posedge clk);
    #1;
    prio_pspin = prio;
    build_expected(prio);
    drive(rmode, vgaps, cyc, nic_first, ps_first);
    while ((exp_q.size() > 0 || nic_q.size() > 0 || ps_q.size() > 0) && cyc < 20000) begin
      if (stop_after > 0 && cyc >= stop_after) break;
      @(negedge clk);
      out_free = !m_valid || m_tready;
      if (prev_stall) begin
        check({tag, " stall hold"}, CW'({m_valid, m_pack()}), CW'({1'b1, snap}));
      end
      if (chk_mirror && !nic_first && nic_q.size() > 0) begin
        check({tag, " nic tready mirror"}, CW'(nic_rdy), CW'(out_free));
      end
      if (prio && ps_q.size() > 0) begin
        check({tag, " nic tready blocked"}, CW'(nic_rdy), CW'(0));
      end
      nic_fire = nic_v && nic_rdy;
      ps_fire  = ps_v && ps_rdy;
      m_fire   = m_valid && m_tready;
      if (m_fire) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s extra beat: got %0h expected none", tag, m_pack());
        end else begin
          e = exp_q.pop_front();
          check({tag, " beat"}, CW'(m_pack()), CW'(pack(e)));
          if (chk_gap) begin
            check({tag, " beat timing"}, CW'(cyc - last_out_cyc), CW'(out_first ? 2 : 1));
          end
          last_out_cyc = cyc;
          out_first = e.last;
        end
      end
      prev_stall = m_valid && !m_tready;
      snap = m_pack();
      @(posedge clk);
      #1;
      if (nic_fire) begin
        b = nic_q.pop_front();
        nic_first = b.last;
      end
      if (ps_fire) begin
        b = ps_q.pop_front();
        ps_first = b.last;
      end
      cyc++;
      drive(rmode, vgaps, cyc, nic_first, ps_first);
    end
    if (stop_after == 0) begin
      check({tag, " all frames done"},
            CW'({32'(exp_q.size()), 32'(nic_q.size()), 32'(ps_q.size())}), CW'(0));
      check_stats(tag);
      nic_v = 1'b0;
      ps_v  = 1'b0;
    end
  endtask

  initial begin
    arb_vec_t arb_tbl [7];
    arb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    arb_tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    arb_tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    arb_tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};  // first tie after reset: NIC
    arb_tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // strict priority: PsPIN
    arb_tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    arb_tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Idle arbitration table
    for (int i = 0; i < 7; i++) begin
      apply_reset();
      if (i == 0) check_reset_state("reset");
      @(posedge clk);
      #1;
      m_tready   = 1'b1;
      prio_pspin = arb_tbl[i].prio;
      nic_v      = arb_tbl[i].nic_v;
      ps_v       = arb_tbl[i].ps_v;
      @(negedge clk);
      check($sformatf("arb[%0d] idle tready", i), CW'({nic_rdy, ps_rdy}), CW'(0));
      @(negedge clk);
      check($sformatf("arb[%0d] grant", i), CW'({nic_rdy, ps_rdy}),
            CW'({arb_tbl[i].exp_nic_rdy, arb_tbl[i].exp_ps_rdy}));
    end

    // Single host frame: latency 2, back-to-back beats, sideband intact
    apply_reset();
    gen_frame(1'b0, 3, 64'h0F, 1'b1, 8'd5, 17'h0);
    run_traffic("single", 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);

    // Round-robin tie, one bubble between frames
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      gen_random_frame(1'b0, 2);
      gen_random_frame(1'b1, 2);
    end
    run_traffic("rr", 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);

    // Strict PsPIN priority
    apply_reset();
    for (int i = 0; i < 3; i++) gen_random_frame(1'b1, 2 + i);
    for (int i = 0; i < 2; i++) gen_random_frame(1'b0, 2);
    run_traffic("strict", 1'b1, 0, 1'b0, 1'b1, 1'b0, 0);

    // Exact-length frame, truncated frame, then a normal frame
    apply_reset();
    gen_random_frame(1'b1, MAX_BEATS);
    gen_random_frame(1'b1, 30);
    gen_random_frame(1'b1, 2);
    run_traffic("trunc", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    // Backpressure 1,0,0,1 in the middle of a frame
    apply_reset();
    gen_random_frame(1'b0, 4);
    run_traffic("bp", 1'b0, 2, 1'b0, 1'b0, 1'b1, 0);

    // Asynchronous reset while beat 2 of a 4-beat frame is on the output
    apply_reset();
    gen_random_frame(1'b0, 4);
    run_traffic("areset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
    #2 rstn = 1'b0;
    #1;
    check_reset_state("mid-frame reset");
    apply_reset();
    gen_random_frame(1'b1, 2);
    gen_random_frame(1'b0, 2);
    run_traffic("post-reset tie", 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);

    // Randomized traffic with valid gaps and random backpressure
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      for (int i = 0; i < 8; i++) begin
        gen_random_frame(1'b0, $urandom_range(1, 30));
        gen_random_frame(1'b1, $urandom_range(1, 30));
      end
      run_traffic($sformatf("random%0d", r), 1'($urandom_range(0, 1)), 1, 1'b1, 1'b0, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pspin_tx_merge.md
# pspin_tx_merge

Egress counterpart of the PsPIN RX packet match engine. Merges two AXI-Stream TX sources, the host NIC TX datapath and the PsPIN egress, into the single NIC TX stream toward the MAC. Arbitration is frame-atomic, so beats from different sources never interleave. Frames longer than the MTU are truncated and flagged bad, so a runaway PsPIN handler cannot stall host traffic.

## Interface
- `AXIS_IF_DATA_WIDTH`, 512, data bus width in bits.
- `AXIS_IF_KEEP_WIDTH`, `AXIS_IF_DATA_WIDTH/8`, tkeep width.
- `AXIS_IF_TX_ID_WIDTH`, 1, tid width.
- `AXIS_IF_TX_DEST_WIDTH`, 8, tdest width.
- `AXIS_IF_TX_USER_WIDTH`, 17, tuser width; bit 0 is the bad-frame flag.
- `MERGE_MTU`, 1500, maximum frame length in bytes.
- Derived `MAX_BEATS` = ceil(`MERGE_MTU`*8/`AXIS_IF_DATA_WIDTH`), which is 24 at the defaults.

Ports:
- `clk`  in  1  single clock domain.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `s_axis_nic_tx_{tdata,tkeep,tvalid,tready(out),tlast,tid,tdest,tuser}`  in  bus  host TX source.
- `s_axis_pspin_tx_{tdata,tkeep,tvalid,tready(out),tlast,tid,tdest,tuser}`  in  bus  PsPIN TX source.
- `m_axis_nic_tx_{tdata,tkeep,tvalid,tready(in),tlast,tid,tdest,tuser}`  out  bus  merged stream to the MAC.
- `prio_pspin`  in  1  arbitration policy: 1 = strict PsPIN priority, 0 = round-robin. Sampled only in IDLE.
- `stat_nic_frames`, `stat_pspin_frames`, `stat_trunc_frames`  out  32 each  frame counters.

## Operation
States: IDLE, PASS_NIC, PASS_PSPIN, DROP_NIC, DROP_PSPIN.

**IDLE**
- Both source tready are 0.
- If either source tvalid is high, select a winner and transition next cycle to the matching PASS state.
- When both are valid:
  - `prio_pspin`=1: PsPIN wins.
  - `prio_pspin`=0: the source not granted last wins.
- The last-granted pointer resets to PsPIN, so NIC wins the first tie after reset.

**PASS_x**
- Granted source tready = output-register-free; the other source tready = 0.
- Each accepted beat is copied into the output register with all sideband unchanged.
- A beat counter increments per accepted beat and clears in IDLE.
- Accepted beat with tlast: go to IDLE and update the last-granted pointer.
- Accepted beat number `MAX_BEATS` without tlast:
  - Output beat has tlast forced to 1 and tuser[0] forced to 1.
  - Go to DROP_x.

**DROP_x**
- Granted source tready = 1.
- Beats are discarded and nothing is emitted.
- On an accepted beat with tlast: go to IDLE and update the pointer.

**Output register**
- Single stage.
- Output-register-free = !`m_tvalid` || `m_tready`.
- `m_tvalid` clears when the held beat is taken and no new beat is loaded.

**Arithmetic**
- Beat counter width is `$clog2(MAX_BEATS+1)`.
- Stat counters are 32 bits and wrap from 0xFFFFFFFF to 0 silently.

## Timing
- **Reset values:** state IDLE; all `m_axis` outputs 0; both s tready 0; beat counter 0; pointer = PsPIN; stats 0.
- **Latency:** input tvalid rising in IDLE gives grant on cycle +1 and first output beat valid on cycle +2.
- **Throughput:** one beat per cycle within a frame while `m_tready`=1.
- **Frame overhead:** one IDLE bubble cycle between frames.
- **Output stalls:** `m_tready`=0 holds all `m_axis` outputs stable and deasserts the granted source tready.
- **tvalid with no beat:** a source that raises and drops tvalid without a handshake during PASS is legal. The grant is held until tlast.
- **Unchanged policy:** a `prio_pspin` change mid-frame has no effect until the next IDLE.
- **Reset mid-frame:** immediate return to the reset values. The partial frame is not completed on the output, and upstream must restart.
- **Exact-length frame:** a frame of exactly `MAX_BEATS` beats with tlast on the last beat passes unmodified and is not counted as truncated.

## Configuration
- Macro `PSPIN_TX_MERGE_STATS_EN`.
- **Defined:**
  - `stat_nic_frames` / `stat_pspin_frames` increment when the final output beat of a frame from that source is loaded into the output register.
  - `stat_trunc_frames` increments on each forced tlast.
- **Undefined:** no counter logic is built and the three stat ports are tied to 0.

## Test plan
- **Single host frame:** a 3-beat NIC frame with tkeep last = 0x0F, tid=1, tdest=5, `m_tready`=1 -> first output beat 2 cycles after tvalid, 3 consecutive beats, identical data and sideband, `stat_nic_frames`=1.
- **Round-robin tie:** `prio_pspin`=0, both sources present 2-beat frames continuously -> output order NIC, PsPIN, NIC, PsPIN, with no interleaved beats and a one-cycle gap between frames.
- **Strict priority:** `prio_pspin`=1, both sources continuously valid -> only PsPIN frames are output and NIC tready stays 0.
- **Truncation:** a 30-beat PsPIN frame at 512-bit width -> 24 output beats with beat 24 tlast=1 and tuser[0]=1, remaining 6 input beats consumed, `stat_trunc_frames`=1, then the next frame is passed normally.
- **Backpressure:** `m_tready` toggled 1,0,0,1 mid-frame -> outputs stable while stalled, no beat lost or duplicated, source tready mirrors the free condition.
- **Async reset:** `rstn` pulled low on beat 2 of a 4-beat frame, between clock edges -> `m_tvalid` is 0 immediately; after release, a new frame passes correctly and the NIC source wins the first tie.
